// File: rtl/disparity_wta_accum_pkg.sv
// -----------------------------------------------------------------------------
// disparity_wta_accum_pkg
//   System-wide constants shared by the argmin tree, the winner-take-all
//   accumulator and downstream consumers, plus the width helpers they use.
//   Every block derives its disparity width from the same functions, so the
//   widths always match.
//
//   Constants:
//     DISPARITIES    total disparity search range
//     COST_WIDTH     aggregated cost word width
//     ARGMIN_INPUTS  disparities reduced per argmin beat
//     SYS_CHUNKS     beats per pixel (DISPARITIES / ARGMIN_INPUTS)
//     SYS_DISP_BITS  disparity width for the system configuration
// -----------------------------------------------------------------------------
package disparity_wta_accum_pkg;

  // Ceiling log2; clog2_f(1) == 0.
  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Chunk counter width; a counter always needs at least one bit.
  function automatic int cnt_bits_f(input int chunks);
    return (chunks > 1) ? clog2_f(chunks) : 1;
  endfunction

  // Global disparity = {chunk number, local index}.
  function automatic int disp_bits_f(input int chunks, input int inputs);
    return clog2_f(chunks) + clog2_f(inputs);
  endfunction

  localparam int DISPARITIES   = 64;
  localparam int COST_WIDTH    = 8;
  localparam int ARGMIN_INPUTS = 8;
  localparam int SYS_CHUNKS    = DISPARITIES / ARGMIN_INPUTS;
  localparam int SYS_DISP_BITS = disp_bits_f(SYS_CHUNKS, ARGMIN_INPUTS);

endpackage

// File: rtl/disparity_wta_accum_running_min.sv
// -----------------------------------------------------------------------------
// wta_running_min
//   Combinational compare/select between the running best (cost, disparity)
//   and the candidate of the current beat. The candidate wins only on a
//   strictly lower cost, so on ties the earlier (lower) disparity is kept.
//   first_i forces the candidate to win (first beat of a pixel, where the
//   running registers hold stale data).
//
//   Ports:
//     first_i       candidate wins unconditionally
//     run_cost_i    running best cost
//     run_disp_i    running best disparity
//     cand_cost_i   candidate cost
//     cand_disp_i   candidate disparity
//     win_cost_o    selected cost
//     win_disp_o    selected disparity
// -----------------------------------------------------------------------------
module wta_running_min #(
  parameter int WIDTH     = 8,
  parameter int DISP_BITS = 6
) (
  input  logic                 first_i,
  input  logic [WIDTH-1:0]     run_cost_i,
  input  logic [DISP_BITS-1:0] run_disp_i,
  input  logic [WIDTH-1:0]     cand_cost_i,
  input  logic [DISP_BITS-1:0] cand_disp_i,
  output logic [WIDTH-1:0]     win_cost_o,
  output logic [DISP_BITS-1:0] win_disp_o
);

  logic take_cand;

  assign take_cand  = first_i || (cand_cost_i < run_cost_i);
  assign win_cost_o = take_cand ? cand_cost_i : run_cost_i;
  assign win_disp_o = take_cand ? cand_disp_i : run_disp_i;

endmodule

// File: rtl/disparity_wta_accum.sv
// -----------------------------------------------------------------------------
// disparity_wta_accum
//   Sequential winner-take-all stage behind the per-beat argmin tree. A pixel's
//   cost vector arrives as CHUNKS beats, each carrying the minimum cost and its
//   local index among INPUTS disparities. The block keeps a running minimum
//   across beats and emits one (disparity, cost) result per pixel.
//
//   Optional feature (macro SGM_WTA_SATURATION_FLAG_EN): out_invalid_o flags a
//   winning cost of all-ones (saturated aggregation). Without the macro the
//   flag is tied to 0.
//
//   Ports:
//     clk              system clock, rising edge
//     rst              asynchronous active-high reset
//     in_valid_i       beat present
//     in_ready_o       beat accepted this cycle (combinational)
//     in_min_value_i   beat minimum cost
//     in_min_index_i   local index of that minimum
//     out_valid_o      result present
//     out_ready_i      consumer accepts result
//     out_disparity_o  winning disparity
//     out_cost_o       winning cost
//     out_invalid_o    saturated-cost flag
// -----------------------------------------------------------------------------
module disparity_wta_accum
  import disparity_wta_accum_pkg::*;
#(
  parameter int  WIDTH      = COST_WIDTH,
  parameter int  INPUTS     = ARGMIN_INPUTS,
  parameter int  CHUNKS     = SYS_CHUNKS,
  localparam int INDEX_BITS = clog2_f(INPUTS),
  localparam int CNT_BITS   = cnt_bits_f(CHUNKS),
  localparam int DISP_BITS  = disp_bits_f(CHUNKS, INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_min_value_i,
  input  logic [INDEX_BITS-1:0] in_min_index_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DISP_BITS-1:0]  out_disparity_o,
  output logic [WIDTH-1:0]      out_cost_o,
  output logic                  out_invalid_o
);

  localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(CHUNKS - 1);

  logic                 in_ready;
  logic                 accept;
  logic                 last_beat;
  logic                 first_beat;
  logic [DISP_BITS-1:0] cand_disp;
  logic [WIDTH-1:0]     win_cost;
  logic [DISP_BITS-1:0] win_disp;

  logic [CNT_BITS-1:0]  chunk_cnt_q, chunk_cnt_d;
  logic [WIDTH-1:0]     run_cost_q,  run_cost_d;
  logic [DISP_BITS-1:0] run_disp_q,  run_disp_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_cost_q,  out_cost_d;
  logic [DISP_BITS-1:0] out_disp_q,  out_disp_d;

  // A held result blocks every beat, mid-pixel ones included, so the running
  // state can never overtake an unconsumed result.
  assign in_ready   = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready;
  assign last_beat  = (chunk_cnt_q == LAST_CHUNK);
  assign first_beat = (chunk_cnt_q == '0);

  // chunk*INPUTS + index is a plain concatenation because INPUTS is a power
  // of two; the cast drops the spare counter bit when CHUNKS == 1.
  assign cand_disp = DISP_BITS'({chunk_cnt_q, in_min_index_i});

  wta_running_min #(
    .WIDTH     (WIDTH),
    .DISP_BITS (DISP_BITS)
  ) u_running_min (
    .first_i     (first_beat),
    .run_cost_i  (run_cost_q),
    .run_disp_i  (run_disp_q),
    .cand_cost_i (in_min_value_i),
    .cand_disp_i (cand_disp),
    .win_cost_o  (win_cost),
    .win_disp_o  (win_disp)
  );

  always_comb begin
    chunk_cnt_d = chunk_cnt_q;
    run_cost_d  = run_cost_q;
    run_disp_d  = run_disp_q;
    out_valid_d = out_valid_q;
    out_cost_d  = out_cost_q;
    out_disp_d  = out_disp_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // A last beat accepted in the same cycle as a consume reloads the
    // outputs and keeps out_valid high.
    if (accept) begin
      if (last_beat) begin
        out_valid_d = 1'b1;
        out_cost_d  = win_cost;
        out_disp_d  = win_disp;
        chunk_cnt_d = '0;
      end else begin
        run_cost_d  = win_cost;
        run_disp_d  = win_disp;
        chunk_cnt_d = chunk_cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_cnt_q <= '0;
      run_cost_q  <= '1;
      run_disp_q  <= '0;
      out_valid_q <= 1'b0;
      out_cost_q  <= '0;
      out_disp_q  <= '0;
    end else begin
      chunk_cnt_q <= chunk_cnt_d;
      run_cost_q  <= run_cost_d;
      run_disp_q  <= run_disp_d;
      out_valid_q <= out_valid_d;
      out_cost_q  <= out_cost_d;
      out_disp_q  <= out_disp_d;
    end
  end

`ifdef SGM_WTA_SATURATION_FLAG_EN
  logic out_invalid_q, out_invalid_d;

  // Registered alongside the result so flag and disparity always match.
  always_comb begin
    out_invalid_d = out_invalid_q;
    if (accept && last_beat) begin
      out_invalid_d = (win_cost == {WIDTH{1'b1}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_invalid_q <= 1'b0;
    end else begin
      out_invalid_q <= out_invalid_d;
    end
  end

  assign out_invalid_o = out_invalid_q;
`else
  assign out_invalid_o = 1'b0;
`endif

  assign in_ready_o      = in_ready;
  assign out_valid_o     = out_valid_q;
  assign out_cost_o      = out_cost_q;
  assign out_disparity_o = out_disp_q;

endmodule
